// File: rtl/layer_sequencer.sv
// Layer chain sequencer: pulses each layer's compute, waits for its done, then
// walks the layer's output memory into the next layer's input memory.
module layer_sequencer #(
    parameter int                          NUM_LAYERS   = 2,
    parameter int                          IDX_W        = 16,
    parameter logic [NUM_LAYERS*IDX_W-1:0] XFER_CH      = {16'd0, 16'd16},
    parameter logic [NUM_LAYERS*IDX_W-1:0] XFER_ROWS    = {16'd0, 16'd26},
    parameter logic [NUM_LAYERS*IDX_W-1:0] XFER_COLS    = {16'd0, 16'd26},
    parameter int                          READ_LATENCY = 1,
    parameter int                          TIMEOUT      = 0,
    parameter bit                          CONTINUOUS   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [NUM_LAYERS-1:0] layer_start,
    output logic [3*IDX_W-1:0]    rd_index,
    output logic [2:0]            rd_src,
    output logic [3*IDX_W-1:0]    wr_index,
    output logic [NUM_LAYERS-1:0] wr_en,
    output logic [2:0]            cur_layer,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_XFER, S_DRAIN, S_FINISH} state_t;

    localparam logic [2:0]  LAST_LAYER = 3'(NUM_LAYERS - 1);
    localparam logic [31:0] WD_LIMIT   = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [2:0]         cur_q, cur_d;
    logic [IDX_W-1:0]   ch_q, ch_d, row_q, row_d, col_q, col_d;
    logic [31:0]        wd_q, wd_d;
    logic               timeout_q, timeout_d;

    logic [IDX_W-1:0]   dim_ch, dim_row, dim_col;
    logic               done_sel, rd_vld, wr_vld, pipe_busy, kill;
    logic [3*IDX_W-1:0] rd_idx, wr_idx;

    assign kill   = abort && (state_q != S_IDLE);
    assign rd_idx = {ch_q, row_q, col_q};
    // Any zero dimension means the transfer has no beats at all.
    assign rd_vld = (state_q == S_XFER) && (dim_ch != '0) && (dim_row != '0) && (dim_col != '0);

    always_comb begin
        dim_ch   = '0;
        dim_row  = '0;
        dim_col  = '0;
        done_sel = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (cur_q == 3'(i)) begin
                dim_ch   = XFER_CH[i*IDX_W +: IDX_W];
                dim_row  = XFER_ROWS[i*IDX_W +: IDX_W];
                dim_col  = XFER_COLS[i*IDX_W +: IDX_W];
                done_sel = layer_done[i];
            end
        end
    end

    // Source read latency compensation: valid/index travel together.
    generate
        if (READ_LATENCY == 0) begin : g_no_lat
            assign wr_vld    = rd_vld;
            assign wr_idx    = rd_idx;
            assign pipe_busy = 1'b0;
        end else begin : g_lat
            logic [READ_LATENCY-1:0]              vld_q, vld_d;
            logic [READ_LATENCY-1:0][3*IDX_W-1:0] idx_q, idx_d;

            always_comb begin
                vld_d    = '0;
                idx_d    = '0;
                vld_d[0] = rd_vld;
                idx_d[0] = rd_idx;
                for (int i = 1; i < READ_LATENCY; i++) begin
                    vld_d[i] = vld_q[i-1];
                    idx_d[i] = idx_q[i-1];
                end
                if (kill) vld_d = '0;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_q <= '0;
                    idx_q <= '0;
                end else begin
                    vld_q <= vld_d;
                    idx_q <= idx_d;
                end
            end

            assign wr_vld    = vld_q[READ_LATENCY-1];
            assign wr_idx    = idx_q[READ_LATENCY-1];
            // Beats still in flight after the current cycle.
            assign pipe_busy = |vld_d;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        ch_d      = ch_q;
        row_d     = row_q;
        col_d     = col_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d   = S_START;
                    cur_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_sel) begin
                    state_d = (cur_q == LAST_LAYER) ? S_FINISH : S_XFER;
                    ch_d    = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else if (TIMEOUT != 0 && wd_q == WD_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                    cur_d     = '0;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
            end
            S_XFER: begin
                if (!rd_vld) begin
                    state_d = S_DRAIN;
                end else if (col_q != dim_col - 1'b1) begin
                    col_d = col_q + 1'b1;
                end else begin
                    col_d = '0;
                    if (row_q != dim_row - 1'b1) begin
                        row_d = row_q + 1'b1;
                    end else begin
                        row_d = '0;
                        if (ch_q != dim_ch - 1'b1) begin
                            ch_d = ch_q + 1'b1;
                        end else begin
                            ch_d    = '0;
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (!pipe_busy) begin
                    state_d = S_START;
                    cur_d   = cur_q + 3'd1;
                end
            end
            S_FINISH: begin
                state_d = CONTINUOUS ? S_START : S_IDLE;
                cur_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
        if (kill) begin
            state_d = S_IDLE;
            cur_d   = '0;
            ch_d    = '0;
            row_d   = '0;
            col_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            ch_q      <= '0;
            row_q     <= '0;
            col_q     <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            ch_q      <= ch_d;
            row_q     <= row_d;
            col_q     <= col_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        layer_start = '0;
        wr_en       = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            layer_start[i] = (state_q == S_START) && (cur_q == 3'(i));
            wr_en[i]       = wr_vld && ((cur_q + 3'd1) == 3'(i));
        end
    end

    assign rd_index  = rd_idx;
    assign rd_src    = cur_q;
    assign wr_index  = wr_idx;
    assign cur_layer = cur_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign timeout   = timeout_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: three instances cover latency 1/3/0,
// watchdog, abort, continuous mode, zero-size transfers and async reset.
module tb_layer_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Instance A: 2 layers, dims {2,2,3}, latency 1, watchdog 10
    logic a_start = 0, a_abort = 0;
    logic [1:0] a_ld = '0, a_ls, a_wen;
    logic [47:0] a_rdi, a_wri;
    logic [2:0] a_rds, a_cur;
    logic a_busy, a_done, a_to;
    layer_sequencer #(.NUM_LAYERS(2), .IDX_W(16), .XFER_CH({16'd0, 16'd2}),
        .XFER_ROWS({16'd0, 16'd2}), .XFER_COLS({16'd0, 16'd3}),
        .READ_LATENCY(1), .TIMEOUT(10), .CONTINUOUS(0)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .abort(a_abort), .layer_done(a_ld),
        .layer_start(a_ls), .rd_index(a_rdi), .rd_src(a_rds), .wr_index(a_wri),
        .wr_en(a_wen), .cur_layer(a_cur), .busy(a_busy), .done(a_done), .timeout(a_to));

    // Instance B: 3 layers, latency 3, continuous
    logic b_start = 0, b_abort = 0;
    logic [2:0] b_ld = '0, b_ls, b_wen;
    logic [47:0] b_rdi, b_wri;
    logic [2:0] b_rds, b_cur;
    logic b_busy, b_done, b_to;
    layer_sequencer #(.NUM_LAYERS(3), .IDX_W(16), .XFER_CH({16'd0, 16'd2, 16'd1}),
        .XFER_ROWS({16'd0, 16'd1, 16'd2}), .XFER_COLS({16'd0, 16'd1, 16'd2}),
        .READ_LATENCY(3), .TIMEOUT(0), .CONTINUOUS(1)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .abort(b_abort), .layer_done(b_ld),
        .layer_start(b_ls), .rd_index(b_rdi), .rd_src(b_rds), .wr_index(b_wri),
        .wr_en(b_wen), .cur_layer(b_cur), .busy(b_busy), .done(b_done), .timeout(b_to));

    // Instance C: 3 layers, latency 0, layer 1 has a zero-size transfer
    logic c_start = 0, c_abort = 0;
    logic [2:0] c_ld = '0, c_ls, c_wen;
    logic [47:0] c_rdi, c_wri;
    logic [2:0] c_rds, c_cur;
    logic c_busy, c_done, c_to;
    layer_sequencer #(.NUM_LAYERS(3), .IDX_W(16), .XFER_CH({16'd0, 16'd0, 16'd1}),
        .XFER_ROWS({16'd0, 16'd4, 16'd1}), .XFER_COLS({16'd0, 16'd4, 16'd3}),
        .READ_LATENCY(0), .TIMEOUT(0), .CONTINUOUS(0)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .abort(c_abort), .layer_done(c_ld),
        .layer_start(c_ls), .rd_index(c_rdi), .rd_src(c_rds), .wr_index(c_wri),
        .wr_en(c_wen), .cur_layer(c_cur), .busy(c_busy), .done(c_done), .timeout(c_to));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] ix(input int ch, input int row, input int col);
        return {16'(ch), 16'(row), 16'(col)};
    endfunction

    task automatic test_reset;
        #1 reset = 1'b0;
        #3;
        n_chk++;
        if ({a_ls, a_wen, a_rdi, a_wri, a_rds, a_cur, a_busy, a_done, a_to} !== '0) begin
            n_fail++; $display("FAIL reset_a: got busy=%b ls=%b wen=%b want all zero", a_busy, a_ls, a_wen);
        end
        n_chk++;
        if ({b_ls, b_wen, b_rdi, b_wri, b_rds, b_cur, b_busy, b_done, b_to} !== '0) begin
            n_fail++; $display("FAIL reset_b: got busy=%b ls=%b wen=%b want all zero", b_busy, b_ls, b_wen);
        end
        n_chk++;
        if ({c_ls, c_wen, c_rdi, c_wri, c_rds, c_cur, c_busy, c_done, c_to} !== '0) begin
            n_fail++; $display("FAIL reset_c: got busy=%b ls=%b wen=%b want all zero", c_busy, c_ls, c_wen);
        end
        #10 reset = 1'b1;
        tick;
    endtask

    task automatic run_a(input string tg);
        logic [1:0] exp_wen;
        a_start = 1; tick; a_start = 0;
        n_chk++;
        if ({a_ls, a_busy, a_cur} !== {2'b01, 1'b1, 3'd0}) begin
            n_fail++; $display("FAIL %s start0: got ls=%b busy=%b cur=%0d want 01/1/0", tg, a_ls, a_busy, a_cur);
        end
        tick;
        n_chk++;
        if ({a_ls, a_busy} !== {2'b00, 1'b1}) begin
            n_fail++; $display("FAIL %s wait0: got ls=%b busy=%b want 00/1", tg, a_ls, a_busy);
        end
        repeat (3) tick;
        a_ld = 2'b01; tick; a_ld = 2'b00;
        for (int k = 0; k <= 12; k++) begin
            if (k < 12) begin
                n_chk++;
                if ({a_rdi, a_rds} !== {ix(k / 6, (k / 3) % 2, k % 3), 3'd0}) begin
                    n_fail++; $display("FAIL %s rd beat %0d: got %h src %0d want %h src 0", tg, k, a_rdi, a_rds, ix(k / 6, (k / 3) % 2, k % 3));
                end
            end
            exp_wen = (k > 0) ? 2'b10 : 2'b00;
            n_chk++;
            if (a_wen !== exp_wen || (k > 0 && a_wri !== ix((k - 1) / 6, ((k - 1) / 3) % 2, (k - 1) % 3))) begin
                n_fail++; $display("FAIL %s wr cycle %0d: got wen=%b idx=%h want wen=%b", tg, k, a_wen, a_wri, exp_wen);
            end
            tick;
        end
        n_chk++;
        if ({a_ls, a_cur, a_wen} !== {2'b10, 3'd1, 2'b00}) begin
            n_fail++; $display("FAIL %s start1: got ls=%b cur=%0d wen=%b want 10/1/00", tg, a_ls, a_cur, a_wen);
        end
        tick;
        a_ld = 2'b10; tick; a_ld = 2'b00;
        n_chk++;
        if ({a_done, a_busy} !== 2'b11) begin
            n_fail++; $display("FAIL %s done: got done=%b busy=%b want 1/1", tg, a_done, a_busy);
        end
        tick;
        n_chk++;
        if ({a_done, a_busy} !== 2'b00) begin
            n_fail++; $display("FAIL %s idle: got done=%b busy=%b want 0/0", tg, a_done, a_busy);
        end
    endtask

    task automatic test_basic;
        run_a("basic");
    endtask

    task automatic test_timeout;
        a_start = 1; tick; a_start = 0;
        for (int i = 1; i <= 10; i++) begin
            tick;
            n_chk++;
            if ({a_busy, a_to, a_done} !== 3'b100) begin
                n_fail++; $display("FAIL wd_wait %0d: got busy=%b to=%b done=%b want 1/0/0", i, a_busy, a_to, a_done);
            end
        end
        tick;
        n_chk++;
        if ({a_busy, a_to, a_done} !== 3'b010) begin
            n_fail++; $display("FAIL wd_fire: got busy=%b to=%b done=%b want 0/1/0", a_busy, a_to, a_done);
        end
        repeat (3) tick;
        n_chk++;
        if ({a_to, a_done} !== 2'b10) begin
            n_fail++; $display("FAIL wd_sticky: got to=%b done=%b want 1/0", a_to, a_done);
        end
        a_start = 1; tick; a_start = 0;
        n_chk++;
        if ({a_busy, a_to} !== 2'b10) begin
            n_fail++; $display("FAIL wd_clear: got busy=%b to=%b want 1/0", a_busy, a_to);
        end
        a_abort = 1; tick; a_abort = 0;
        n_chk++;
        if ({a_busy, a_done, a_to} !== 3'b000) begin
            n_fail++; $display("FAIL abort_wait: got busy=%b done=%b to=%b want 0/0/0", a_busy, a_done, a_to);
        end
        a_start = 1; a_abort = 1; tick; a_start = 0; a_abort = 0;
        n_chk++;
        if ({a_busy, a_ls} !== 3'b000) begin
            n_fail++; $display("FAIL abort_beats_start: got busy=%b ls=%b want 0/00", a_busy, a_ls);
        end
    endtask

    task automatic test_abort;
        int late;
        a_start = 1; tick; a_start = 0;
        tick;
        a_ld = 2'b01; tick; a_ld = 2'b00;
        repeat (4) tick;
        n_chk++;
        if ({a_rdi, a_wen} !== {ix(0, 1, 1), 2'b10}) begin
            n_fail++; $display("FAIL abort_pre: got rd=%h wen=%b want %h/10", a_rdi, a_wen, ix(0, 1, 1));
        end
        a_abort = 1; tick; a_abort = 0;
        n_chk++;
        if ({a_busy, a_wen, a_ls, a_done} !== 6'b0) begin
            n_fail++; $display("FAIL abort_xfer: got busy=%b wen=%b ls=%b done=%b want 0", a_busy, a_wen, a_ls, a_done);
        end
        late = 0;
        repeat (20) begin
            tick;
            if (a_wen !== 2'b00 || a_done !== 1'b0 || a_busy !== 1'b0) late++;
        end
        n_chk++;
        if (late !== 0) begin
            n_fail++; $display("FAIL abort_after: got %0d active cycles want 0", late);
        end
    endtask

    task automatic test_latency3;
        logic [2:0] exp_wen;
        b_start = 1; tick; b_start = 0;
        n_chk++;
        if ({b_ls, b_cur} !== {3'b001, 3'd0}) begin
            n_fail++; $display("FAIL lat3 start0: got ls=%b cur=%0d want 001/0", b_ls, b_cur);
        end
        tick;
        b_ld = 3'b001; tick; b_ld = 3'b000;
        for (int j = 0; j <= 6; j++) begin
            if (j < 4) begin
                n_chk++;
                if ({b_rdi, b_rds} !== {ix(0, j / 2, j % 2), 3'd0}) begin
                    n_fail++; $display("FAIL lat3 rd0 %0d: got %h src %0d want %h src 0", j, b_rdi, b_rds, ix(0, j / 2, j % 2));
                end
            end
            exp_wen = (j >= 3) ? 3'b010 : 3'b000;
            n_chk++;
            if (b_wen !== exp_wen || (j >= 3 && b_wri !== ix(0, (j - 3) / 2, (j - 3) % 2))) begin
                n_fail++; $display("FAIL lat3 wr0 %0d: got wen=%b idx=%h want wen=%b", j, b_wen, b_wri, exp_wen);
            end
            tick;
        end
        n_chk++;
        if ({b_ls, b_cur, b_wen} !== {3'b010, 3'd1, 3'b000}) begin
            n_fail++; $display("FAIL lat3 start1: got ls=%b cur=%0d wen=%b want 010/1/000", b_ls, b_cur, b_wen);
        end
        tick;
        b_ld = 3'b010; tick; b_ld = 3'b000;
        for (int j = 0; j <= 4; j++) begin
            if (j < 2) begin
                n_chk++;
                if ({b_rdi, b_rds} !== {ix(j, 0, 0), 3'd1}) begin
                    n_fail++; $display("FAIL lat3 rd1 %0d: got %h src %0d want %h src 1", j, b_rdi, b_rds, ix(j, 0, 0));
                end
            end
            exp_wen = (j >= 3) ? 3'b100 : 3'b000;
            n_chk++;
            if (b_wen !== exp_wen || (j >= 3 && b_wri !== ix(j - 3, 0, 0))) begin
                n_fail++; $display("FAIL lat3 wr1 %0d: got wen=%b idx=%h want wen=%b", j, b_wen, b_wri, exp_wen);
            end
            tick;
        end
        n_chk++;
        if ({b_ls, b_cur} !== {3'b100, 3'd2}) begin
            n_fail++; $display("FAIL lat3 start2: got ls=%b cur=%0d want 100/2", b_ls, b_cur);
        end
        tick;
        b_ld = 3'b100; tick; b_ld = 3'b000;
        n_chk++;
        if ({b_done, b_busy} !== 2'b11) begin
            n_fail++; $display("FAIL lat3 done: got done=%b busy=%b want 1/1", b_done, b_busy);
        end
    endtask

    task automatic test_continuous;
        tick;
        n_chk++;
        if ({b_ls, b_cur, b_done, b_busy} !== {3'b001, 3'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL cont restart: got ls=%b cur=%0d done=%b busy=%b want 001/0/0/1", b_ls, b_cur, b_done, b_busy);
        end
        b_start = 1; tick; b_start = 0;
        n_chk++;
        if ({b_ls, b_cur, b_busy} !== {3'b000, 3'd0, 1'b1}) begin
            n_fail++; $display("FAIL cont start_ignored: got ls=%b cur=%0d busy=%b want 000/0/1", b_ls, b_cur, b_busy);
        end
        repeat (3) tick;
        n_chk++;
        if ({b_ls, b_busy} !== {3'b000, 1'b1}) begin
            n_fail++; $display("FAIL cont still_wait: got ls=%b busy=%b want 000/1", b_ls, b_busy);
        end
        b_abort = 1; tick; b_abort = 0;
        n_chk++;
        if ({b_busy, b_ls, b_wen, b_done} !== 8'b0) begin
            n_fail++; $display("FAIL cont abort: got busy=%b ls=%b wen=%b done=%b want 0", b_busy, b_ls, b_wen, b_done);
        end
        repeat (2) tick;
        n_chk++;
        if ({b_busy, b_ls} !== 4'b0) begin
            n_fail++; $display("FAIL cont stays_idle: got busy=%b ls=%b want 0/000", b_busy, b_ls);
        end
    endtask

    task automatic test_zero_dim;
        c_start = 1; tick; c_start = 0;
        tick;
        c_ld = 3'b001; tick; c_ld = 3'b000;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if ({c_rdi, c_wen, c_wri} !== {ix(0, 0, k), 3'b010, ix(0, 0, k)}) begin
                n_fail++; $display("FAIL lat0 beat %0d: got rd=%h wen=%b wr=%h want %h/010/%h", k, c_rdi, c_wen, c_wri, ix(0, 0, k), ix(0, 0, k));
            end
            tick;
        end
        n_chk++;
        if ({c_wen, c_busy} !== {3'b000, 1'b1}) begin
            n_fail++; $display("FAIL lat0 drain: got wen=%b busy=%b want 000/1", c_wen, c_busy);
        end
        tick;
        n_chk++;
        if ({c_ls, c_cur} !== {3'b010, 3'd1}) begin
            n_fail++; $display("FAIL lat0 start1: got ls=%b cur=%0d want 010/1", c_ls, c_cur);
        end
        tick;
        c_ld = 3'b010; tick; c_ld = 3'b000;
        n_chk++;
        if ({c_wen, c_busy, c_ls} !== {3'b000, 1'b1, 3'b000}) begin
            n_fail++; $display("FAIL zero xfer: got wen=%b busy=%b ls=%b want 000/1/000", c_wen, c_busy, c_ls);
        end
        tick;
        n_chk++;
        if ({c_wen, c_busy} !== {3'b000, 1'b1}) begin
            n_fail++; $display("FAIL zero drain: got wen=%b busy=%b want 000/1", c_wen, c_busy);
        end
        tick;
        n_chk++;
        if ({c_ls, c_cur} !== {3'b100, 3'd2}) begin
            n_fail++; $display("FAIL zero start2: got ls=%b cur=%0d want 100/2", c_ls, c_cur);
        end
        tick;
        c_ld = 3'b100; tick; c_ld = 3'b000;
        n_chk++;
        if (c_done !== 1'b1) begin
            n_fail++; $display("FAIL zero done: got %b want 1", c_done);
        end
        tick;
        n_chk++;
        if ({c_done, c_busy} !== 2'b00) begin
            n_fail++; $display("FAIL zero idle: got done=%b busy=%b want 0/0", c_done, c_busy);
        end
    endtask

    task automatic test_reset_mid;
        a_start = 1; tick; a_start = 0;
        tick;
        a_ld = 2'b01; tick; a_ld = 2'b00;
        repeat (3) tick;
        n_chk++;
        if (a_wen !== 2'b10) begin
            n_fail++; $display("FAIL rst_pre: got wen=%b want 10", a_wen);
        end
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if ({a_ls, a_wen, a_rdi, a_wri, a_rds, a_cur, a_busy, a_done, a_to} !== '0) begin
            n_fail++; $display("FAIL rst_async: got busy=%b wen=%b rd=%h wr=%h want all zero", a_busy, a_wen, a_rdi, a_wri);
        end
        #3 reset = 1'b1;
        tick;
        run_a("post_reset");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_timeout;
        test_abort;
        test_latency3;
        test_continuous;
        test_zero_dim;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
